fifo_rd_stream_adapter: RTL and testbench
=========================================

// Module: fifo_rd_stream_adapter
//
// PURPOSE
//   Read-side consumer for fifo_async / fifo_sync style FIFOs in the read clock domain.
//   - FIFO side: empty / read strobe / combinational read-data port.
//   - Stream side: registered valid/ready output through a 2-entry skid buffer.
//   - o_fifo_read does not depend on downstream i_ready, so there is no combinational path
//     from the consumer back into the FIFO pointers.
//   - Sustains 1 beat/clk.
//
// PARAMETERS
//   DATA_WIDTH     8           width of FIFO data and stream data
//   COUNT_WIDTH    16          width of statistics counters (FIFO_RD_ADAPTER_STATS_EN only)
//   INSTANCE_NAME  "RDADAPT0"  string used in simulation error messages
//
// PORTS
//   i_clk           in   1   clock (FIFO read clock)
//   i_rst           in   1   reset, asynchronous, active-high
//   i_enable        in   1   1 = adapter may pop the FIFO; 0 = hold, still drains the skid buffer
//   i_flush         in   1   synchronous discard of buffered beats
//   i_fifo_empty    in   1   FIFO empty flag
//   i_fifo_data     in   DW  FIFO combinational read data; valid when !i_fifo_empty
//   o_fifo_read     out  1   FIFO pop strobe
//   o_valid         out  1   stream valid
//   o_data          out  DW  stream data (registered head entry)
//   i_ready         in   1   stream ready
//   o_count         out  2   beats held in skid buffer (0..2)
//   o_idle          out  1   o_count==0 && i_fifo_empty
//
// BEHAVIOUR
//   Reset values (async, while i_rst=1):
//   - count=0, o_valid=0, o_data=0, buf1=0.
//   - o_fifo_read=0 (gated by i_rst).
//   FIFO pop:
//   - o_fifo_read = !i_rst && i_enable && !i_flush && !i_fifo_empty && (count<2).
//   Stream:
//   - push = o_fifo_read; pop = o_valid && i_ready.
//   - o_valid = (count!=0), registered via the state.
//   - o_data = head register. o_valid/o_data stay stable while i_ready=0.
//   States (count):
//   - EMPTY(0): push -> ONE, head<=i_fifo_data.
//   - ONE(1):
//     - push&pop -> ONE, head<=i_fifo_data.
//     - push&!pop -> TWO, buf1<=i_fifo_data.
//     - pop&!push -> EMPTY.
//     - else hold.
//   - TWO(2): pop -> ONE, head<=buf1. Push is impossible in TWO.
//   Latency:
//   - FIFO non-empty at cycle N with count=0 -> pop at N -> o_valid=1 at N+1.
//   Flush (priority over push/pop state update):
//   - Next state EMPTY; o_fifo_read=0 that cycle.
//   - A beat handshaked (o_valid&&i_ready) in the flush cycle counts as delivered.
//   - Contents of head/buf1 are don't-care after flush. o_data holds its last value.
//   Other rules:
//   - i_enable=0 only blocks pops; buffered beats still drain on i_ready.
//   - Reset mid-transfer discards buffered beats. The FIFO is not popped during reset.
//   - Simulation only: $display error if the FIFO is popped while i_fifo_empty=1 (cannot
//     occur by construction), or if o_data changes while o_valid && !i_ready.
//
// CONFIGURATION
//   Macro FIFO_RD_ADAPTER_STATS_EN.
//   Defined: adds ports
//   - o_beat_count   out  COUNT_WIDTH   +1 per handshake (o_valid&&i_ready).
//   - o_stall_count  out  COUNT_WIDTH   +1 per cycle with o_valid&&!i_ready.
//   - Both saturate at all-ones, reset to 0 on i_rst, and are unaffected by i_flush.
//   Not defined:
//   - Ports and counters are absent.
//   - All other behaviour is identical.
//
// TESTING
//   1. FIFO pre-loaded with 0x11,0x22,0x33; i_ready=1 throughout
//      -> pops on 3 consecutive clks; o_data 0x11,0x22,0x33 on 3 consecutive clks from N+1;
//         then o_idle=1.
//   2. i_ready=0 with 4 beats in FIFO
//      -> exactly 2 pops, o_count=2, o_fifo_read=0 afterwards, o_data=first beat, stable;
//      then raise i_ready -> all 4 beats delivered in order, no gaps after the first.
//   3. Random i_ready (50%) with 256 random beats
//      -> output sequence equals input sequence, no loss or duplication, o_count never exceeds 2.
//   4. o_count=2, assert i_flush one clk with i_ready=0
//      -> o_count=0, o_valid=0 next clk; no pop in flush cycle; next FIFO beat delivered after.
//   5. Assert i_rst mid-stream with o_count=1
//      -> o_valid=0, o_data=0, o_fifo_read=0 immediately (async); resumes after deassert.
//   6. FIFO_RD_ADAPTER_STATS_EN, COUNT_WIDTH=4, 20 handshakes and 3 stall cycles
//      -> o_beat_count=15 (saturated), o_stall_count=3.

Source files
------------

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - FIFO read-side pop logic feeding a 2-entry valid/ready skid buffer.
// Optional statistics counters are compiled in with `define FIFO_RD_ADAPTER_STATS_EN.
module fifo_rd_stream_adapter #(
  parameter int    DATA_WIDTH    = 8,
  parameter int    COUNT_WIDTH   = 16,
  parameter string INSTANCE_NAME = "RDADAPT0"
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_flush,
  input  logic                   i_fifo_empty,
  input  logic [DATA_WIDTH-1:0]  i_fifo_data,
  output logic                   o_fifo_read,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  input  logic                   i_ready,
  output logic [1:0]             o_count,
`ifdef FIFO_RD_ADAPTER_STATS_EN
  output logic [COUNT_WIDTH-1:0] o_beat_count,
  output logic [COUNT_WIDTH-1:0] o_stall_count,
`endif
  output logic                   o_idle
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   head_q, head_d;
  logic [DATA_WIDTH-1:0]   buf1_q, buf1_d;
  logic                    push, pop;

  // Pop decision never looks at i_ready, keeping the consumer off the FIFO pointer path.
  assign o_fifo_read = !i_rst && i_enable && !i_flush && !i_fifo_empty &&
                       (state_q == EMPTY || state_q == ONE);
  assign push        = o_fifo_read;
  assign pop         = o_valid && i_ready;
  assign o_valid     = (state_q != EMPTY);
  assign o_data      = head_q;
  assign o_count     = state_q;
  assign o_idle      = (state_q == EMPTY) && i_fifo_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      buf1_q  <= buf1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    buf1_d  = buf1_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          head_d  = i_fifo_data;
        end
        ONE: begin
          if (push && pop) begin
            head_d = i_fifo_data;
          end else if (push) begin
            state_d = TWO;
            buf1_d  = i_fifo_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d = ONE;
          head_d  = buf1_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [COUNT_WIDTH-1:0] beat_q, stall_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pop && !(&beat_q)) beat_q <= beat_q + 1'b1;
      if (o_valid && !i_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end

  assign o_beat_count  = beat_q;
  assign o_stall_count = stall_q;
`endif

  // Simulation-only sanity checks; synthesis ignores the assertions.
  logic                  hold_q;
  logic [DATA_WIDTH-1:0] prev_data_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q      <= 1'b0;
      prev_data_q <= '0;
    end else begin
      hold_q      <= o_valid && !i_ready;
      prev_data_q <= o_data;
    end
  end

  always @(posedge i_clk) begin
    if (!i_rst) begin
      assert (COUNT_WIDTH > 0)
        else $error("%s: COUNT_WIDTH must be positive", INSTANCE_NAME);
      assert (!(o_fifo_read && i_fifo_empty))
        else $error("%s: FIFO popped while empty", INSTANCE_NAME);
      assert (!hold_q || (o_data == prev_data_q))
        else $error("%s: o_data changed while stalled", INSTANCE_NAME);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb/tb_fifo_rd_stream_adapter.sv - directed bench for fifo_rd_stream_adapter with a behavioural FIFO.
module tb_fifo_rd_stream_adapter;

`ifdef FIFO_RD_ADAPTER_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        flush = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_read;
  logic        valid;
  logic [7:0]  data;
  logic        ready = 1'b0;
  logic [1:0]  count;
  logic        idle;
`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [CW-1:0] beat_count, stall_count;
`endif

  logic [7:0]  mem [0:1023];
  logic [31:0] rd = 0;
  logic [31:0] wr = 0;
  logic [7:0]  rx [0:1023];
  int          rx_n = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd == wr);
  assign fifo_data  = mem[rd[9:0]];

  always @(posedge clk) begin
    if (fifo_read) rd <= rd + 1;
    if (!rst && valid && ready) begin
      rx[rx_n[9:0]] <= data;
      rx_n          <= rx_n + 1;
    end
  end

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .COUNT_WIDTH(CW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_flush      (flush),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_read  (fifo_read),
    .o_valid      (valid),
    .o_data       (data),
    .i_ready      (ready),
    .o_count      (count),
`ifdef FIFO_RD_ADAPTER_STATS_EN
    .o_beat_count (beat_count),
    .o_stall_count(stall_count),
`endif
    .o_idle       (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr[9:0]] = v;
    wr = wr + 1;
  endtask

  logic [7:0]  exp3 [0:255];
  logic [31:0] rd0;
  int          s, errs, maxc, n;

  initial begin
    // Reset state and preload for the back-to-back case
    tick(); tick();
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_count", count, 0);
    chk("rst_idle", idle, 1);
    push(8'h11); push(8'h22); push(8'h33);
    ready = 1'b1;
    #1;
    chk("rst_gates_read", fifo_read, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t1_read_N", fifo_read, 1);
    tick(); chk("t1_valid0", valid, 1); chk("t1_d0", data, 8'h11);
    tick(); chk("t1_d1", data, 8'h22);
    tick(); chk("t1_d2", data, 8'h33); chk("t1_read_off", fifo_read, 0);
    tick(); chk("t1_valid_end", valid, 0); chk("t1_idle", idle, 1);

    // Back-pressure fills the skid buffer, then drains without gaps
    ready = 1'b0;
    rd0 = rd;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    tick(); tick(); tick(); tick();
    chk("t2_count", count, 2);
    chk("t2_pops", rd - rd0, 2);
    chk("t2_read_off", fifo_read, 0);
    chk("t2_head", data, 8'hA1);
    ready = 1'b1;
    #1;
    chk("t2_d0", data, 8'hA1);
    tick(); chk("t2_v1", valid, 1); chk("t2_d1", data, 8'hA2);
    tick(); chk("t2_v2", valid, 1); chk("t2_d2", data, 8'hA3);
    tick(); chk("t2_v3", valid, 1); chk("t2_d3", data, 8'hA4);
    tick(); chk("t2_drained", valid, 0);

    // Random back-pressure over 256 random beats
    s = rx_n;
    for (int i = 0; i < 256; i++) begin
      exp3[i] = 8'($urandom);
      push(exp3[i]);
    end
    maxc = 0;
    n = 0;
    while ((rx_n - s) < 256 && n < 4000) begin
      ready = 1'($urandom_range(0, 1));
      tick();
      if (int'(count) > maxc) maxc = int'(count);
      n++;
    end
    ready = 1'b1;
    tick(); tick(); tick();
    chk("t3_beats", rx_n - s, 256);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (rx[(s + i) % 1024] !== exp3[i]) errs++;
    chk("t3_order", errs, 0);
    chk("t3_maxcount_le2", (maxc <= 2), 1);
    chk("t3_idle", idle, 1);

    // Flush with a full skid buffer and a stalled consumer
    ready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3);
    tick(); tick();
    chk("t4_full", count, 2);
    flush = 1'b1;
    #1;
    chk("t4_no_pop", fifo_read, 0);
    tick();
    flush = 1'b0;
    chk("t4_count", count, 0);
    chk("t4_valid", valid, 0);
    chk("t4_data_held", data, 8'hB1);
    #1;
    chk("t4_read_after", fifo_read, 1);
    tick(); chk("t4_v_next", valid, 1); chk("t4_d_next", data, 8'hB3);
    ready = 1'b1;
    tick(); chk("t4_drained", valid, 0);

    // Asynchronous reset with one beat buffered
    ready = 1'b0;
    push(8'hC1);
    tick();
    chk("t5_pre_count", count, 1);
    chk("t5_pre_data", data, 8'hC1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid", valid, 0);
    chk("t5_data", data, 0);
    chk("t5_count", count, 0);
    push(8'hC2);
    #1;
    chk("t5_read", fifo_read, 0);
    rd0 = rd;
    tick();
    chk("t5_no_pop_in_rst", rd - rd0, 0);
    rst = 1'b0;
    ready = 1'b1;
    tick(); chk("t5_resume_v", valid, 1); chk("t5_resume_d", data, 8'hC2);
    tick(); chk("t5_drained", valid, 0);

    // Disabling only blocks pops
    enable = 1'b0;
    push(8'hE1);
    #1;
    chk("en_blocks", fifo_read, 0);
    tick();
    chk("en_hold_valid", valid, 0);
    enable = 1'b1;
    #1;
    chk("en_resumes", fifo_read, 1);
    tick(); chk("en_d", data, 8'hE1);
    tick(); chk("en_drained", valid, 0);

`ifdef FIFO_RD_ADAPTER_STATS_EN
    // 3 stall cycles then 20 handshakes into a 4-bit saturating counter
    rst = 1'b1;
    ready = 1'b0;
    for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    ready = 1'b1;
    n = 0;
    while (!idle && n < 200) begin
      tick();
      n++;
    end
    chk("t6_done", idle, 1);
    chk("t6_beats", beat_count, 4'hF);
    chk("t6_stalls", stall_count, 4'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
